// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate generator.
// Optional feature macro: IMMGEN_CSR_ZIMM_EN (adds FMT_Z decode for CSR*I instructions).
package imm_pkg;

    localparam int IMM_FMT_W = 3;

    typedef enum logic [IMM_FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extraction: instruction -> {imm, fmt, illeg}.
// Optional feature macro: IMMGEN_CSR_ZIMM_EN (CSR*I zimm decoded as FMT_Z).
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]             instr,
    output logic signed [XLEN-1:0]  imm,
    output imm_fmt_e                fmt,
    output logic                    illeg
);

    logic signed [31:0] raw;

    // Reassemble the scattered immediate into a 32-bit signed value, then widen to XLEN
    always_comb begin
        raw   = '0;
        fmt   = FMT_NONE;
        illeg = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                fmt = FMT_I;
                raw = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_SYSTEM: begin
`ifdef IMMGEN_CSR_ZIMM_EN
                if (instr[14]) begin
                    fmt = FMT_Z;
                    raw = {27'b0, instr[19:15]};
                end else begin
                    fmt = FMT_I;
                    raw = {{20{instr[31]}}, instr[31:20]};
                end
`else
                fmt = FMT_I;
                raw = {{20{instr[31]}}, instr[31:20]};
`endif
            end
            OPC_STORE: begin
                fmt = FMT_S;
                raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                raw = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt = FMT_J;
                raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                illeg = 1'b1;
            end
        endcase
        // raw is signed, so the size cast replicates bit 31 (zimm keeps bit 31 clear)
        imm = XLEN'(raw);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, one output register and a one-entry skid buffer
// with valid/ready handshake and flush.
// Optional feature macro: IMMGEN_CSR_ZIMM_EN (passed through to imm_decode).
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ILEN-1:0]  in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic [ILEN-1:0]  out_instr,
    output logic             out_illeg
);

    logic signed [XLEN-1:0] dec_imm_p0;
    imm_fmt_e               dec_fmt_p0;
    logic                   dec_illeg_p0;

    logic                   vld_p1;
    logic signed [XLEN-1:0] imm_p1;
    imm_fmt_e               fmt_p1;
    logic [ILEN-1:0]        instr_p1;
    logic                   illeg_p1;

    logic                   skid_vld;
    logic signed [XLEN-1:0] skid_imm;
    imm_fmt_e               skid_fmt;
    logic [ILEN-1:0]        skid_instr;
    logic                   skid_illeg;

    logic [1:0]             rst_sync;
    logic                   rst_int_n;
    logic                   accept;
    logic                   drain;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .imm   (dec_imm_p0),
        .fmt   (dec_fmt_p0),
        .illeg (dec_illeg_p0)
    );

    // Reset asserts asynchronously, releases two edges after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // The skid only ever fills while the output register is stalled, so an empty skid
    // guarantees room for one more transfer
    assign in_ready = !skid_vld;
    assign accept   = in_valid && in_ready;
    assign drain    = !vld_p1 || out_ready;

    // ---- stage p0 -> p1: output register, skid has priority over the new input ----
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            vld_p1   <= 1'b0;
            imm_p1   <= '0;
            fmt_p1   <= FMT_NONE;
            instr_p1 <= '0;
            illeg_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
        end else if (drain) begin
            if (skid_vld) begin
                vld_p1   <= 1'b1;
                imm_p1   <= skid_imm;
                fmt_p1   <= skid_fmt;
                instr_p1 <= skid_instr;
                illeg_p1 <= skid_illeg;
            end else begin
                vld_p1   <= accept;
                if (accept) begin
                    imm_p1   <= dec_imm_p0;
                    fmt_p1   <= dec_fmt_p0;
                    instr_p1 <= in_instr;
                    illeg_p1 <= dec_illeg_p0;
                end
            end
        end
    end

    // Skid captures a transfer accepted while the output register is stalled
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            skid_vld   <= 1'b0;
            skid_imm   <= '0;
            skid_fmt   <= FMT_NONE;
            skid_instr <= '0;
            skid_illeg <= 1'b0;
        end else if (flush || drain) begin
            skid_vld   <= 1'b0;
        end else if (accept) begin
            skid_vld   <= 1'b1;
            skid_imm   <= dec_imm_p0;
            skid_fmt   <= dec_fmt_p0;
            skid_instr <= in_instr;
            skid_illeg <= dec_illeg_p0;
        end
    end

    assign out_valid = vld_p1;
    assign out_imm   = imm_p1;
    assign out_fmt   = fmt_p1;
    assign out_instr = instr_p1;
    assign out_illeg = illeg_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share stimulus
// and are compared against a queue-based transaction model with an arithmetic decoder.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;

    logic        in_ready_a, out_valid_a, out_illeg_a;
    logic [31:0] out_imm_a, out_instr_a;
    logic [2:0]  out_fmt_a;
    logic        in_ready_b, out_valid_b, out_illeg_b;
    logic [63:0] out_imm_b;
    logic [31:0] out_instr_b;
    logic [2:0]  out_fmt_b;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        illeg;
    } item_t;

    item_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .ILEN(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
        .out_fmt(out_fmt_a), .out_instr(out_instr_a), .out_illeg(out_illeg_a)
    );

    imm_gen_pipe #(.XLEN(64), .ILEN(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
        .out_fmt(out_fmt_b), .out_instr(out_instr_b), .out_illeg(out_illeg_b)
    );

    function automatic longint fld(input logic [31:0] w, input int lo, input int n);
        logic [31:0] v;
        v = (w >> lo) & ((32'd1 << n) - 32'd1);
        return longint'(v);
    endfunction

    // Reference decoder: immediate value computed as a weighted sum of instruction fields
    function automatic item_t ref_dec(input logic [31:0] w);
        item_t  it;
        longint s, sg, v;
        s  = longint'($signed(w));
        sg = s >>> 31;
        it.instr = w;
        it.illeg = 1'b0;
        v = 0;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: begin it.fmt = 3'd1; v = s >>> 20; end
            7'h73: begin
`ifdef IMMGEN_CSR_ZIMM_EN
                if (w[14]) begin it.fmt = 3'd6; v = fld(w, 15, 5); end
                else begin it.fmt = 3'd1; v = s >>> 20; end
`else
                it.fmt = 3'd1; v = s >>> 20;
`endif
            end
            7'h23: begin it.fmt = 3'd2; v = (s >>> 25) * 32 + fld(w, 7, 5); end
            7'h63: begin
                it.fmt = 3'd3;
                v = sg * 4096 + fld(w, 7, 1) * 2048 + fld(w, 25, 6) * 32 + fld(w, 8, 4) * 2;
            end
            7'h37, 7'h17: begin it.fmt = 3'd4; v = (s >>> 12) * 4096; end
            7'h6F: begin
                it.fmt = 3'd5;
                v = sg * 1048576 + fld(w, 12, 8) * 4096 + fld(w, 20, 1) * 2048 + fld(w, 21, 10) * 2;
            end
            default: begin it.fmt = 3'd0; it.illeg = 1'b1; v = 0; end
        endcase
        it.imm = v;
        return it;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic exp_rdy, exp_vld;
        exp_rdy = (q.size() < 2);
        exp_vld = (q.size() > 0);
        chk("in_ready_a", in_ready_a, exp_rdy);
        chk("in_ready_b", in_ready_b, exp_rdy);
        chk("out_valid_a", out_valid_a, exp_vld);
        chk("out_valid_b", out_valid_b, exp_vld);
        if (exp_vld) begin
            chk("imm_a", out_imm_a, q[0].imm[31:0]);
            chk("imm_b", out_imm_b, q[0].imm);
            chk("fmt_a", out_fmt_a, q[0].fmt);
            chk("fmt_b", out_fmt_b, q[0].fmt);
            chk("instr_a", out_instr_a, q[0].instr);
            chk("instr_b", out_instr_b, q[0].instr);
            chk("illeg_a", out_illeg_a, q[0].illeg);
            chk("illeg_b", out_illeg_b, q[0].illeg);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid_a"}, out_valid_a, 1'b0);
        chk({tag, "_valid_b"}, out_valid_b, 1'b0);
        chk({tag, "_ready_a"}, in_ready_a, 1'b1);
        chk({tag, "_ready_b"}, in_ready_b, 1'b1);
        chk({tag, "_imm_a"}, out_imm_a, 64'd0);
        chk({tag, "_imm_b"}, out_imm_b, 64'd0);
        chk({tag, "_fmt_a"}, out_fmt_a, 3'd0);
        chk({tag, "_fmt_b"}, out_fmt_b, 3'd0);
        chk({tag, "_instr_a"}, out_instr_a, 32'd0);
        chk({tag, "_illeg_a"}, out_illeg_a, 1'b0);
    endtask

    // Called just after a falling edge: drive one cycle, advance the model, check next cycle
    task automatic step(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
        logic acc, drn;
        in_valid  = iv;
        in_instr  = w;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (q.size() < 2) && !fl;
        drn = (q.size() > 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ref_dec(w));
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic directed(input string tag, input logic [31:0] w, input logic [63:0] exp_imm,
                            input logic [2:0] exp_fmt, input logic exp_ill);
        step(1'b1, w, 1'b1, 1'b0);
        chk({tag, "_dvalid"}, out_valid_a, 1'b1);
        chk({tag, "_dimm32"}, out_imm_a, exp_imm[31:0]);
        chk({tag, "_dimm64"}, out_imm_b, exp_imm);
        chk({tag, "_dfmt"}, out_fmt_a, exp_fmt);
        chk({tag, "_dilleg"}, out_illeg_a, exp_ill);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    logic [6:0] opc_tab [10] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B};

    initial begin
        logic [31:0] w;
        // Reset state
        repeat (2) @(negedge clk);
        check_reset("rst");
        release_reset();

        // Directed decode cases
        directed("addi", 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        directed("sw",   32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
        directed("jal",  32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);
        directed("lui1", 32'h123452B7, 64'h0000000012345000, 3'd4, 1'b0);
        directed("lui2", 32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
`ifdef IMMGEN_CSR_ZIMM_EN
        directed("csrwi", 32'h300FD073, 64'h000000000000001F, 3'd6, 1'b0);
`else
        directed("csrwi", 32'h300FD073, 64'h0000000000000300, 3'd1, 1'b0);
`endif
        directed("illeg", 32'h0000000B, 64'h0, 3'd0, 1'b1);
        directed("beq",  32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Back-pressure: A held, B in skid, C refused, then in-order delivery
        step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        step(1'b1, 32'hFE112E23, 1'b0, 1'b0);
        step(1'b1, 32'hFFDFF06F, 1'b0, 1'b0);
        chk("stall_hold_A", out_instr_a, 32'hFFF00093);
        chk("stall_ready", in_ready_a, 1'b0);
        step(1'b1, 32'hFFDFF06F, 1'b1, 1'b0);
        chk("drain_B", out_instr_a, 32'hFE112E23);
        step(1'b1, 32'hFFDFF06F, 1'b1, 1'b0);
        chk("drain_C", out_instr_a, 32'hFFDFF06F);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("drain_empty", out_valid_a, 1'b0);

        // Flush with stage full and a new input presented
        step(1'b1, 32'h123452B7, 1'b0, 1'b0);
        step(1'b1, 32'h800002B7, 1'b0, 1'b0);
        step(1'b1, 32'h00A00513, 1'b0, 1'b1);
        chk("flush_valid", out_valid_a, 1'b0);
        chk("flush_ready", in_ready_a, 1'b1);
        repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a stall
        step(1'b1, 32'h123452B7, 1'b0, 1'b0);
        step(1'b1, 32'h800002B7, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        q.delete();
        in_valid = 1'b0;
        release_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            w = $urandom();
            w[6:0] = opc_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) w[6:0] = 7'($urandom());
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
